// File: rtl/rv32i_types.sv
// Shared types for the rv32i core slice.
// Holds the data-memory responder FSM state encoding and the latched
// request record that the responder keeps between acceptance and commit.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Request captured in IDLE; index is the full word index so the range
    // check can see every address bit.
    typedef struct packed {
        logic [29:0] index;
        logic [31:0] wdata;
        logic [3:0]  byte_enable;
        logic        is_write;
        logic        fault;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Data-memory storage: DEPTH_WORDS x 32 bits, no reset.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable
//   be     in  4-lane byte mask for writes (bit i -> byte i)
//   addr   in  word address shared by the read and write ports
//   wdata  in  write data
//   re     in  read enable; rdata loads mem[addr] on the edge
//   rdata  out registered read data, holds between reads
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Behavioural data-memory responder for the CPU load/store path.
// Accepts one read or write at a time, holds it LATENCY cycles, commits on
// the edge entering RESP, then pulses mem_resp for one cycle.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   mem_read          read request, held until mem_resp
//   mem_write         write request, held until mem_resp
//   mem_address       byte address (bits [1:0] ignored)
//   mem_wdata         lane-aligned write data
//   mem_byte_enable   write lane mask
//   mem_rdata         read data, valid in the resp cycle of a read
//   mem_resp          one-cycle completion pulse
//   mem_err           with mem_resp: completed request was faulted
// Handshake: a request is a level held by the requester; it is complete when
// mem_resp is seen high. Dropping both request lines while the responder is
// counting abandons the request with no side effects.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_t state, state_n;
    logic [3:0]  cnt, cnt_n;
    dmem_req_t   req, req_n, fresh, cur;
    logic        req_any;
    logic        commit;
    logic        arr_we, arr_re;
    logic        zero_q;
    logic [31:0] arr_rdata;
    logic        unused_bits;

    assign req_any = mem_read | mem_write;

    always_comb begin
        fresh             = '0;
        fresh.index       = mem_address[31:2];
        fresh.wdata       = mem_wdata;
        fresh.byte_enable = mem_byte_enable;
        fresh.is_write    = mem_write;
        fresh.fault       = (mem_address[31:2] >= 30'(DEPTH_WORDS)) ||
                            (mem_read && mem_write);
    end

    // Next state. `cur` is the request being committed this edge: the
    // fresh inputs when LATENCY==1 (accept and commit share an edge),
    // otherwise the latched copy.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = req;
        cur     = req;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    req_n = fresh;
                    cnt_n = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        cur     = fresh;
                        commit  = 1'b1;
                    end else begin
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req_any) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_n = RESP;
                    cnt_n   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Gated by rst_n so a reset edge never writes or reads the array.
    assign arr_we = rst_n && commit && cur.is_write && !cur.fault;
    assign arr_re = rst_n && commit && !cur.is_write && !cur.fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            req    <= '0;
            zero_q <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            req   <= req_n;
            // zero_q masks the array read register: set on reset and on
            // faulted commits, cleared when a good read loads new data.
            if (commit && cur.fault) begin
                zero_q <= 1'b1;
            end else if (arr_re) begin
                zero_q <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .be   (cur.byte_enable),
        .addr (cur.index[AW-1:0]),
        .wdata(cur.wdata),
        .re   (arr_re),
        .rdata(arr_rdata)
    );

    // All three outputs come from registers only.
    assign mem_resp  = (state == RESP);
    assign mem_err   = (state == RESP) && req.fault;
    assign mem_rdata = zero_q ? 32'd0 : arr_rdata;

    assign unused_bits = ^{mem_address[1:0], cur.index[29:AW]};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Four instances share one set of request inputs
// and differ only in LATENCY (2, 1, 15, 4); each scenario looks at the
// outputs of the instance it targets.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;

    logic [31:0] rdata_v [4];
    logic        resp_v  [4];
    logic        err_v   [4];

    int checks   = 0;
    int failures = 0;
    int lat_tab [4] = '{2, 1, 15, 4};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_responder #(
            .LATENCY    ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 4),
            .DEPTH_WORDS(256)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .mem_read       (mem_read),
            .mem_write      (mem_write),
            .mem_address    (mem_address),
            .mem_wdata      (mem_wdata),
            .mem_byte_enable(mem_byte_enable),
            .mem_rdata      (rdata_v[g]),
            .mem_resp       (resp_v[g]),
            .mem_err        (err_v[g])
        );
    end

    // ---------------- driver ----------------
    // Called at a negedge. Holds the request until instance `sel` responds
    // (bounded), drops it, then steps one more cycle and reports whether
    // mem_resp was still high (tail). lat = 0 means no response seen.
    task automatic do_req(input int sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat,
                          output logic [31:0] rdata, output logic err,
                          output logic tail);
        lat   = 0;
        rdata = 32'd0;
        err   = 1'b0;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_v[sel] === 1'b1) begin
                lat   = i;
                rdata = rdata_v[sel];
                err   = err_v[sel];
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tail = resp_v[sel];
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 32'd0; mem_wdata = 32'd0; mem_byte_enable = 4'd0;
        idle_cycles(3);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (resp_v[s] !== 1'b0) begin
                failures++; $display("FAIL reset_resp[%0d] got=%b exp=0", s, resp_v[s]);
            end
            checks++;
            if (err_v[s] !== 1'b0) begin
                failures++; $display("FAIL reset_err[%0d] got=%b exp=0", s, err_v[s]);
            end
            checks++;
            if (rdata_v[s] !== 32'd0) begin
                failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", s, rdata_v[s]);
            end
        end
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic err, tail;
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, err, tail);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", err); end
        checks++;
        if (tail !== 1'b0) begin failures++; $display("FAIL wr_pulse_width got=%b exp=0", tail); end
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", err); end
        checks++;
        if (tail !== 1'b0) begin failures++; $display("FAIL rd_pulse_width got=%b exp=0", tail); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic err, tail;
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, err, tail);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0001, lat, rd, err, tail);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (rd !== 32'h112233DD) begin failures++; $display("FAIL lane_be0001 got=%h exp=112233dd", rd); end
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h55660000, 4'b1100, lat, rd, err, tail);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (rd !== 32'h556633DD) begin failures++; $display("FAIL lane_be1100 got=%h exp=556633dd", rd); end
        // be == 0 must still respond but change nothing
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, err, tail);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL be0_latency got=%0d exp=2", lat); end
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (rd !== 32'h556633DD) begin failures++; $display("FAIL be0_data got=%h exp=556633dd", rd); end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd; logic err, tail;
        do_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL oob_latency got=%0d exp=2", lat); end
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL oob_err got=%b exp=1", err); end
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL oob_rdata got=%h exp=0", rd); end
        do_req(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF, lat, rd, err, tail);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL both_err got=%b exp=1", err); end
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL both_unchanged got=%h exp=deadbeef", rd); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL good_read_err got=%b exp=0", err); end
        // a write must leave mem_rdata holding the last read value
        do_req(0, 1'b0, 1'b1, 32'h14, 32'h01020304, 4'hF, lat, rd, err, tail);
        checks++;
        if (rdata_v[0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rdata_hold got=%h exp=deadbeef", rdata_v[0]);
        end
    endtask

    task automatic test_latency_sweep();
        int first [4];
        int cnt   [4];
        int last  [4];
        int badgap[4];
        int exp_cnt;
        for (int s = 0; s < 4; s++) begin
            first[s] = 0; cnt[s] = 0; last[s] = 0; badgap[s] = 0;
        end
        mem_read = 1'b1; mem_write = 1'b0;
        mem_address = 32'h30; mem_wdata = 32'h0; mem_byte_enable = 4'h0;
        for (int n = 1; n <= 48; n++) begin
            @(posedge clk);
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                if (resp_v[s] === 1'b1) begin
                    if (cnt[s] == 0) first[s] = n;
                    else if (n - last[s] != lat_tab[s] + 1) badgap[s]++;
                    last[s] = n;
                    cnt[s]++;
                end
            end
        end
        mem_read = 1'b0;
        idle_cycles(3);
        for (int s = 0; s < 4; s++) begin
            exp_cnt = (48 - lat_tab[s]) / (lat_tab[s] + 1) + 1;
            checks++;
            if (first[s] !== lat_tab[s]) begin
                failures++; $display("FAIL sweep_first[L=%0d] got=%0d exp=%0d", lat_tab[s], first[s], lat_tab[s]);
            end
            checks++;
            if (cnt[s] !== exp_cnt) begin
                failures++; $display("FAIL sweep_count[L=%0d] got=%0d exp=%0d", lat_tab[s], cnt[s], exp_cnt);
            end
            checks++;
            if (badgap[s] !== 0) begin
                failures++; $display("FAIL sweep_gap[L=%0d] bad_gaps=%0d exp=0", lat_tab[s], badgap[s]);
            end
        end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic err, tail;
        int seen;
        do_req(3, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, lat, rd, err, tail);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL l4_latency got=%0d exp=4", lat); end
        mem_write = 1'b1; mem_address = 32'h40; mem_wdata = 32'hCAFEF00D; mem_byte_enable = 4'hF;
        idle_cycles(2);
        mem_write = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_v[3] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL abort_resp got=%0d pulses exp=0", seen); end
        do_req(3, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (rd !== 32'h12345678) begin failures++; $display("FAIL abort_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic err, tail;
        mem_write = 1'b1; mem_address = 32'h40; mem_wdata = 32'h0BADF00D; mem_byte_enable = 4'hF;
        idle_cycles(2);
        rst_n = 1'b0;
        idle_cycles(1);
        checks++;
        if (resp_v[3] !== 1'b0) begin failures++; $display("FAIL midrst_resp got=%b exp=0", resp_v[3]); end
        checks++;
        if (err_v[3] !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err_v[3]); end
        checks++;
        if (rdata_v[3] !== 32'd0) begin failures++; $display("FAIL midrst_rdata got=%h exp=0", rdata_v[3]); end
        rst_n = 1'b1;
        mem_write = 1'b0;
        idle_cycles(1);
        do_req(3, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, err, tail);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 32'h12345678) begin failures++; $display("FAIL midrst_data got=%h exp=12345678", rd); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_faults();
        test_latency_sweep();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory interface driven by the control word (mem_read, mem_write, mem_byte_enable). Sits at the far end of the load/store path. Accepts one read or write request at a time, holds it for a fixed latency, then answers with a one-cycle mem_resp. Serves as the behavioural data memory for core simulation and as the template for a later cache-facing responder.

## Interface
- LATENCY, 2: cycles from request acceptance to mem_resp; legal range 1..15.
- DEPTH_WORDS, 256: 32-bit words of storage; power of two.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- mem_read  in  1  read request; held high until mem_resp.
- mem_write  in  1  write request; held high until mem_resp.
- mem_address  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data, already lane-aligned by the datapath.
- mem_byte_enable  in  4  write lane mask; bit i enables byte i.
- mem_rdata  out  32  read data; valid in the mem_resp cycle of a read.
- mem_resp  out  1  one-cycle completion pulse.
- mem_err  out  1  high with mem_resp when the completed request was faulted.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: when mem_read or mem_write is high, latch the following:
  - address word index (mem_address[31:2]), wdata, byte_enable, op;
  - fault flag (word index >= DEPTH_WORDS, or read and write both high).
  - Load cnt = LATENCY-1.
  - Go to RESP if LATENCY == 1, else BUSY.
- BUSY: decrement cnt each cycle; when cnt reaches 1, go to RESP on the next edge.
- Abort: if both mem_read and mem_write are low in any BUSY cycle, return to IDLE. No write, no resp, no rdata update.
- Commit happens on the edge entering RESP:
  - Write, not faulted: update only the enabled byte lanes of the word. be == 0 writes nothing but still responds.
  - Read, not faulted: mem_rdata <= word contents.
  - Faulted: no array update; mem_rdata <= 0.
- RESP: mem_resp = 1; mem_err = latched fault flag. Always return to IDLE next cycle.
- The request still high during the RESP cycle is the completed one and is not re-accepted. IDLE samples requests again from the following cycle.
- mem_rdata holds its last value except at read/fault commits.
- The storage array has no reset. Contents are retained across rst_n and are X at time zero.

## Timing
- Request first high in IDLE at cycle T → mem_resp high in cycle T+LATENCY, exactly one cycle.
- Back-to-back throughput: one request per LATENCY+1 cycles.
  - After RESP at T+LATENCY, IDLE at T+LATENCY+1 accepts the next request.
  - Its response comes at T+2·LATENCY+1.
- Read-after-write to the same word returns the written data, because the write commits before the later read's commit edge.
- Reset (rst_n low at an edge), in any state:
  - next state IDLE, cnt = 0;
  - mem_resp = 0, mem_err = 0, mem_rdata = 0;
  - any in-flight request is dropped without writing.
- Outputs are registered. No combinational path from inputs to mem_resp, mem_err or mem_rdata.

## Structure
- Package rv32i_types gains:
  - enum dmem_state_t {IDLE, BUSY, RESP};
  - typedef struct dmem_req_t {word index, wdata, byte_enable, is_write, fault}, used for the latched request.
- Sub-module dmem_array:
  - DEPTH_WORDS × 32 storage;
  - 4-lane byte-enable write port;
  - one synchronous read port;
  - no reset.
- The FSM, counter and fault logic live in dmem_responder.

## Test plan
- Write then read, LATENCY=2:
  - SW to 0x10 with 0xDEADBEEF, be=1111 → mem_resp at T+2, mem_err=0.
  - Then read 0x10 → mem_rdata=0xDEADBEEF at its resp cycle.
- Byte lanes:
  - Word 0x20 holds 0x11223344.
  - Write 0xAABBCCDD with be=0001 → read returns 0x112233DD.
  - Then be=1100 with 0x55660000 → read returns 0x556633DD.
- Faults:
  - Read at byte address 4·DEPTH_WORDS → mem_resp with mem_err=1, mem_rdata=0.
  - Read and write both high → mem_err=1 and memory unchanged on readback.
- Latency sweep: LATENCY=1 and LATENCY=15 builds, back-to-back reads → resp spacing of 2 and 16 cycles, with exactly one pulse each.
- Abort: drop mem_write during BUSY with LATENCY=4 → no mem_resp; readback shows the old data.
- Reset mid-operation: assert rst_n low during BUSY of a write → outputs all 0 next cycle, target word unchanged, next request responds normally.
